// File: rtl/seg_serial_disp.sv
`default_nettype none
// ============================================================================
// Module   : seg_serial_disp
// Purpose  : Serial driver for a chain of shift-register seven-segment digits.
//            Builds one byte per digit (hex decode or raw pattern, decimal
//            point, blanking, leading-zero suppression), snapshots the whole
//            frame, then clears the chain, shifts the frame out MSB-first and
//            pulses frame_done. Frames are requested by a free-running refresh
//            timer or by force_update.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   data         in   4*DIGITS  hex nibble per digit, digit i = data[4i+3:4i]
//   raw          in   8*DIGITS  raw pattern per digit {a,b,c,d,e,f,g,p}, 1 = lit
//   mode         in   0 = hex decode, 1 = raw
//   dp_mask      in   DIGITS    1 lights the point of digit i
//   blank_mask   in   DIGITS    1 forces digit i fully dark
//   lz_blank     in   hex mode: suppress leading zero digits
//   force_update in   request a frame
//   segclk       out  shift clock to the chain (chain samples on rising edge)
//   segclrn      out  chain clear, active-low
//   segsout      out  serial data
//   segen        out  display enable (low while a frame is being loaded)
//   busy         out  frame in progress
//   frame_done   out  one-cycle pulse at the end of each frame
// ============================================================================
module seg_serial_disp #(
  parameter int DIGITS     = 8,     // at least 2
  parameter int CLK_DIV    = 1024,  // refresh period, longer than one frame
  parameter int SCLK_HALF  = 2,     // clk cycles per segclk half-period, >= 1
  parameter int ACTIVE_LOW = 1      // 1: lit segment is shifted as 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [8*DIGITS-1:0]   raw,
  input  logic                  mode,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_blank,
  input  logic                  force_update,
  output logic                  segclk,
  output logic                  segclrn,
  output logic                  segsout,
  output logic                  segen,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int c_BITS   = 8 * DIGITS;
  localparam int c_TMR_W  = $clog2(CLK_DIV);
  localparam int c_BIT_W  = $clog2(c_BITS);
  localparam int c_CNT_W  = $clog2(2 * SCLK_HALF) + 1;

  localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(CLK_DIV - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST  = c_BIT_W'(c_BITS - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(SCLK_HALF - 1);
  localparam logic [c_CNT_W-1:0] c_CLR_LAST  = c_CNT_W'(2 * SCLK_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLR   = 2'd1,
    S_SHIFT = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Hex nibble to abcdefg (a = MSB)
  // --------------------------------------------------------------------------
  function automatic logic [6:0] f_hex(input logic [3:0] nib);
    case (nib)
      4'h0:    f_hex = 7'h7E;
      4'h1:    f_hex = 7'h30;
      4'h2:    f_hex = 7'h6D;
      4'h3:    f_hex = 7'h79;
      4'h4:    f_hex = 7'h33;
      4'h5:    f_hex = 7'h5B;
      4'h6:    f_hex = 7'h5F;
      4'h7:    f_hex = 7'h70;
      4'h8:    f_hex = 7'h7F;
      4'h9:    f_hex = 7'h7B;
      4'hA:    f_hex = 7'h77;
      4'hB:    f_hex = 7'h1F;
      4'hC:    f_hex = 7'h4E;
      4'hD:    f_hex = 7'h3D;
      4'hE:    f_hex = 7'h4F;
      default: f_hex = 7'h47;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Frame assembly from the live inputs. Digit 0 lands in the top byte so a
  // plain left shift emits digit 0 first, segment a first.
  // --------------------------------------------------------------------------
  logic [c_BITS-1:0]   w_frame;
  logic [DIGITS-1:1]   w_zero_run;  // this digit and every digit above it is 0

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] w_nib;
    logic [6:0] w_code;
    logic       w_sup;
    logic [7:0] w_byte;

    assign w_nib  = data[4*i +: 4];
    assign w_code = f_hex(w_nib);

    if (i == 0) begin : g_lsd
      // The least significant digit always shows, even when every digit is 0.
      assign w_sup = 1'b0;
    end else begin : g_upper
      if (i == DIGITS - 1) begin : g_top
        assign w_zero_run[i] = (w_nib == 4'h0);
      end else begin : g_mid
        assign w_zero_run[i] = (w_nib == 4'h0) & w_zero_run[i+1];
      end
      assign w_sup = lz_blank & ~mode & w_zero_run[i];
    end

    always_comb begin
      if (blank_mask[i]) begin
        w_byte = 8'h00;
      end else if (mode) begin
        w_byte = {raw[8*i+1 +: 7], raw[8*i] | dp_mask[i]};
      end else begin
        // Suppressed digits lose only a..g; the point still follows dp_mask.
        w_byte = {(w_sup ? 7'h00 : w_code), dp_mask[i]};
      end
    end

    assign w_frame[c_BITS-1-8*i -: 8] = (ACTIVE_LOW != 0) ? ~w_byte : w_byte;
  end

  // --------------------------------------------------------------------------
  // Refresh timer and request flag
  // --------------------------------------------------------------------------
  logic [c_TMR_W-1:0] r_timer;
  logic               r_pending;
  logic               w_req;
  logic               w_snap;

  assign w_req = (r_timer == c_TMR_LAST) | force_update;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (r_timer == c_TMR_LAST) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Comes out of reset set so a frame is drawn immediately. A request that
  // coincides with the snapshot is already satisfied by that snapshot, so the
  // clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b1;
    end else if (w_snap) begin
      r_pending <= 1'b0;
    end else if (w_req) begin
      r_pending <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM and serialiser
  // --------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               r_hi;        // current bit is in its segclk-high half
  logic               w_hi_nxt;
  logic [c_BIT_W-1:0] r_bit;
  logic [c_BIT_W-1:0] w_bit_nxt;
  logic [c_BITS-1:0]  r_shadow;
  logic [c_BITS-1:0]  w_shadow_nxt;
  logic               w_shift;

  logic r_segclk, r_segclrn, r_segsout, r_segen, r_busy, r_frame_done;
  logic w_segclk_nxt, w_segclrn_nxt, w_segsout_nxt, w_segen_nxt;
  logic w_busy_nxt, w_frame_done_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_bit_nxt   = r_bit;
    w_snap      = 1'b0;
    w_shift     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_snap      = 1'b1;
          w_state_nxt = S_CLR;
          w_cnt_nxt   = '0;
        end
      end
      S_CLR: begin
        if (r_cnt == c_CLR_LAST) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_hi_nxt    = 1'b0;
          w_bit_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_cnt == c_HALF_LAST) begin
          w_cnt_nxt = '0;
          if (!r_hi) begin
            w_hi_nxt = 1'b1;
          end else begin
            // End of the high half: advance to the next bit while segclk falls.
            w_hi_nxt = 1'b0;
            w_shift  = 1'b1;
            if (r_bit == c_BIT_LAST) begin
              w_state_nxt = S_LATCH;
            end else begin
              w_bit_nxt = r_bit + 1'b1;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_LATCH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_snap) begin
      w_shadow_nxt = w_frame;
    end else if (w_shift) begin
      w_shadow_nxt = {r_shadow[c_BITS-2:0], 1'b0};
    end else begin
      w_shadow_nxt = r_shadow;
    end

    // Outputs are decoded from the next state and stored in flops, so the
    // pins carry a pure state decode without combinational glitches.
    w_segclk_nxt     = 1'b0;
    w_segclrn_nxt    = 1'b1;
    w_segsout_nxt    = 1'b0;
    w_segen_nxt      = 1'b1;
    w_busy_nxt       = 1'b0;
    w_frame_done_nxt = 1'b0;

    case (w_state_nxt)
      S_CLR: begin
        w_segclrn_nxt = 1'b0;
        w_segen_nxt   = 1'b0;
        w_busy_nxt    = 1'b1;
      end
      S_SHIFT: begin
        w_segclk_nxt  = w_hi_nxt;
        w_segsout_nxt = w_shadow_nxt[c_BITS-1];
        w_segen_nxt   = 1'b0;
        w_busy_nxt    = 1'b1;
      end
      S_LATCH: begin
        w_frame_done_nxt = 1'b1;
        w_segen_nxt      = 1'b0;
        w_busy_nxt       = 1'b1;
      end
      default: begin
        w_segen_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_hi         <= 1'b0;
      r_bit        <= '0;
      r_shadow     <= '0;
      r_segclk     <= 1'b0;
      r_segclrn    <= 1'b1;
      r_segsout    <= 1'b0;
      r_segen      <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hi         <= w_hi_nxt;
      r_bit        <= w_bit_nxt;
      r_shadow     <= w_shadow_nxt;
      r_segclk     <= w_segclk_nxt;
      r_segclrn    <= w_segclrn_nxt;
      r_segsout    <= w_segsout_nxt;
      r_segen      <= w_segen_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign segclk     = r_segclk;
  assign segclrn    = r_segclrn;
  assign segsout    = r_segsout;
  assign segen      = r_segen;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire
